swap_sequencer: RTL and testbench

Upstream controller for the 8-bit swap register. It accepts an operand pair plus a swap count over a valid/ready handshake. It drives the swap register's X, Y and swap_loadBar inputs: one load cycle, then N swap cycles. It then captures the register's A/B outputs and presents them downstream over a second valid/ready handshake.

---
 rtl/swap_sequencer_if.sv | 31 +++
 rtl/swap_sequencer.sv | 90 +++++++++
 tb/tb_swap_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/swap_sequencer_if.sv
// Handshake and swap-register bus for swap_sequencer.
// The slave modport is the sequencer's view. The master modport is the surrounding environment: requester, swap register and result sink.
interface swap_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic [CNT_W-1:0] in_count;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             swap_loadBar;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;

  modport slave (
    input  in_valid, in_x, in_y, in_count, A, B, out_ready,
    output in_ready, X, Y, swap_loadBar, out_valid, out_a, out_b
  );

  modport master (
    output in_valid, in_x, in_y, in_count, A, B, out_ready,
    input  in_ready, X, Y, swap_loadBar, out_valid, out_a, out_b
  );
endinterface

// File: rtl/swap_sequencer.sv
// Sequencer for the 8-bit swap register.
// It loads an operand pair, applies N swaps, then captures A/B and hands them downstream.
module swap_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              resetBar,
  swap_sequencer_if.slave   bus,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SWAP,
    CAPTURE,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;

  assign reg_a        = bus.A;
  assign reg_b        = bus.B;
  assign bus.in_ready = (state == IDLE);
  assign busy         = (state != IDLE);

  // swap_loadBar is registered one state ahead, so it is high exactly for the SWAP cycles
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      state            <= IDLE;
      count            <= '0;
      bus.X            <= '0;
      bus.Y            <= '0;
      bus.swap_loadBar <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_a        <= '0;
      bus.out_b        <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.swap_loadBar <= 1'b0;
          if (bus.in_valid) begin
            bus.X <= bus.in_x;
            bus.Y <= bus.in_y;
            count <= bus.in_count;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (count != '0) begin
            bus.swap_loadBar <= 1'b1;
            state            <= SWAP;
          end else begin
            bus.swap_loadBar <= 1'b0;
            state            <= CAPTURE;
          end
        end
        SWAP: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            bus.swap_loadBar <= 1'b0;
            state            <= CAPTURE;
          end
        end
        // The register reloads X/Y at this edge, but the sampled A/B are the pre-edge values
        CAPTURE: begin
          bus.swap_loadBar <= 1'b0;
          bus.out_a        <= reg_a;
          bus.out_b        <= reg_b;
          bus.out_valid    <= 1'b1;
          state            <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swap_sequencer.sv
// Scoreboard bench for swap_sequencer, with a behavioural swap register model that has a 2 ns output delay.
// Requests are directed vectors with hand-computed results. A negedge monitor checks value, latency and swap count.
module tb_swap_sequencer;

  logic clk;
  logic resetBar;
  logic busy;
  int   cyc;
  int   compared;
  int   mismatched;
  int   lb_count;
  bit   seen;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         edge_at;
    int         swaps;
  } exp_t;

  exp_t q[$];

  swap_sequencer_if #(.WIDTH(8), .CNT_W(4)) bus ();

  swap_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
    .clk      (clk),
    .resetBar (resetBar),
    .bus      (bus.slave),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // The swap register loads or swaps on each edge, and its outputs appear 2 ns later
  always @(posedge clk) begin
    logic       lb;
    logic [7:0] na;
    logic [7:0] nb;
    lb = bus.swap_loadBar;
    na = lb ? bus.B : bus.X;
    nb = lb ? bus.A : bus.Y;
    #2;
    bus.A = na;
    bus.B = nb;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Compares each result once, when out_valid first rises
  always @(negedge clk) begin
    exp_t e;
    if (bus.swap_loadBar) lb_count++;
    if (bus.out_valid && !seen) begin
      seen = 1'b1;
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_out_valid: got out_a=%0h out_b=%0h expected no result", bus.out_a, bus.out_b);
      end else begin
        e = q.pop_front();
        checkOutput("out_a", bus.out_a, e.a);
        checkOutput("out_b", bus.out_b, e.b);
        checkOutput("latency_edge", cyc, e.edge_at);
        checkOutput("swap_cycles", lb_count, e.swaps);
      end
      lb_count = 0;
    end
    if (!bus.out_valid) seen = 1'b0;
  end

  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic [3:0] cnt,
                               input logic [7:0] ea, input logic [7:0] eb, input bit keep);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    @(negedge clk);
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_count = cnt;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_x     = ~x;
    bus.in_y     = ~y;
    bus.in_count = ~cnt;
    if (keep) begin
      e.a       = ea;
      e.b       = eb;
      e.edge_at = cyc + int'(cnt) + 2;
      e.swaps   = int'(cnt);
      q.push_back(e);
    end
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) return;
    end
    compared++;
    mismatched++;
    $display("[TB] FAIL idle_timeout: got busy=%0d pending=%0d expected idle", busy, q.size());
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cyc           = 0;
    compared      = 0;
    mismatched    = 0;
    lb_count      = 0;
    seen          = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b1;
    resetBar      = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_count  = '0;

    // Reset with random inputs applied
    #3;
    bus.in_x     = 8'($urandom);
    bus.in_y     = 8'($urandom);
    bus.in_count = 4'($urandom);
    bus.in_valid = 1'($urandom);
    resetBar     = 1'b0;
    #1;
    checkOutput("rst_X", bus.X, 8'h00);
    checkOutput("rst_Y", bus.Y, 8'h00);
    checkOutput("rst_out_a", bus.out_a, 8'h00);
    checkOutput("rst_out_b", bus.out_b, 8'h00);
    checkOutput("rst_loadBar", bus.swap_loadBar, 1'b0);
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_in_ready", bus.in_ready, 1'b1);
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    resetBar     = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_busy", busy, 1'b0);

    applyStimulus(8'h3C, 8'hA5, 4'd1, 8'hA5, 8'h3C, 1'b1);
    waitIdle();
    applyStimulus(8'h11, 8'h22, 4'd0, 8'h11, 8'h22, 1'b1);
    waitIdle();
    applyStimulus(8'hFF, 8'h00, 4'd15, 8'h00, 8'hFF, 1'b1);
    waitIdle();
    applyStimulus(8'hFF, 8'h00, 4'd4, 8'hFF, 8'h00, 1'b1);
    waitIdle();

    // Backpressure: result must hold while in_valid pulses are ignored
    bus.out_ready = 1'b0;
    applyStimulus(8'h5A, 8'hC3, 4'd2, 8'h5A, 8'hC3, 1'b1);
    for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_x     = 8'h77;
      bus.in_y     = 8'h88;
      bus.in_count = 4'd1;
      @(negedge clk);
      checkOutput("hold_out_valid", bus.out_valid, 1'b1);
      checkOutput("hold_out_a", bus.out_a, 8'h5A);
      checkOutput("hold_out_b", bus.out_b, 8'hC3);
      checkOutput("hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_busy", busy, 1'b0);
    checkOutput("release_out_valid", bus.out_valid, 1'b0);
    applyStimulus(8'h01, 8'h02, 4'd3, 8'h02, 8'h01, 1'b1);
    waitIdle();

    // Asynchronous reset while the swap sequence is running
    applyStimulus(8'h99, 8'h66, 4'd10, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("mid_loadBar", bus.swap_loadBar, 1'b1);
    #2;
    resetBar = 1'b0;
    #1;
    checkOutput("abort_X", bus.X, 8'h00);
    checkOutput("abort_Y", bus.Y, 8'h00);
    checkOutput("abort_loadBar", bus.swap_loadBar, 1'b0);
    checkOutput("abort_out_valid", bus.out_valid, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    lb_count = 0;
    resetBar = 1'b1;
    repeat (15) @(negedge clk);
    checkOutput("abort_no_result", bus.out_valid, 1'b0);
    applyStimulus(8'hAA, 8'h55, 4'd2, 8'hAA, 8'h55, 1'b1);
    waitIdle();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
